// File: rtl/mac_result_drain.sv
// mac_result_drain: captures one row of MAC accumulators and drains it as a
// valid/ready word stream, pulsing mac_clear once per accepted capture.
// Optional macro MAC_DRAIN_DROP_CNT_EN enables a saturating counter of
// capture strobes that arrive while a row is still draining.
module mac_result_drain #(
  parameter int unsigned N_MAC = 4,
  parameter int unsigned ACC_W = 16,
  parameter int unsigned IDX_W = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     capture,
  input  logic [N_MAC*ACC_W-1:0]   acc_in,
  output logic                     capture_ready,
  output logic                     mac_clear,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [ACC_W-1:0]         out_data,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_last,
  output logic [7:0]               drop_cnt
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_MAC - 1);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t                        state_q, state_d;
  logic [N_MAC-1:0][ACC_W-1:0]   row_q, row_d;
  logic [IDX_W-1:0]              idx_q, idx_d;
  logic [ACC_W-1:0]              data_q, data_d;
  logic                          last_q, last_d;
  logic                          valid_q, valid_d;
  logic                          ready_q, ready_d;
  logic                          clear_q, clear_d;

  // State and output registers; reset abandons any row in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      row_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
      clear_q <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      last_q  <= last_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      clear_q <= clear_d;
    end
  end

  // Next-state and next-output logic; the presented word is precomputed so
  // every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    idx_d   = idx_q;
    data_d  = data_q;
    last_d  = last_q;
    valid_d = valid_q;
    ready_d = ready_q;
    clear_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          row_d   = acc_in;
          idx_d   = '0;
          data_d  = acc_in[ACC_W-1:0];
          last_d  = (LAST_IDX == '0);
          valid_d = 1'b1;
          ready_d = 1'b0;
          clear_d = 1'b1;
        end
      end
      SEND: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
            last_d  = 1'b0;
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            data_d = row_q[idx_d];
            last_d = (idx_d == LAST_IDX);
          end
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
        ready_d = 1'b1;
      end
    endcase
  end

  assign capture_ready = ready_q;
  assign mac_clear     = clear_q;
  assign out_valid     = valid_q;
  assign out_data      = data_q;
  assign out_idx       = idx_q;
  assign out_last      = last_q;

`ifdef MAC_DRAIN_DROP_CNT_EN
  logic [7:0] drop_q, drop_d;

  // Saturating count of captures that arrive while a row is draining.
  always_comb begin
    drop_d = drop_q;
    if (state_q == SEND && capture && drop_q != 8'hFF) begin
      drop_d = drop_q + 8'd1;
    end
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      drop_q <= '0;
    end else begin
      drop_q <= drop_d;
    end
  end

  assign drop_cnt = drop_q;
`else
  assign drop_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_mac_result_drain.sv
// Bench for mac_result_drain: table of rows with ready patterns and busy
// captures, plus hand sequences for drop saturation and reset mid-row.
module tb_mac_result_drain;

  logic        clk = 1'b0;
  logic        reset;
  logic        capture;
  logic [63:0] acc_in;
  logic        capture_ready;
  logic        mac_clear;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic [1:0]  out_idx;
  logic        out_last;
  logic [7:0]  drop_cnt;

  mac_result_drain #(.N_MAC(4), .ACC_W(16), .IDX_W(2)) dut (
    .clk(clk), .reset(reset), .capture(capture), .acc_in(acc_in),
    .capture_ready(capture_ready), .mac_clear(mac_clear),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_idx(out_idx), .out_last(out_last), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] d;
    logic [1:0]  i;
    logic        l;
  } exp_t;

  // cap: 0 none, 1 single capture in first drain cycle, 2 capture every drain cycle
  typedef struct packed {
    logic [63:0] acc;
    logic [7:0]  rdy;
    logic [1:0]  cap;
    logic [7:0]  cyc;
  } vec_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   drops  = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
  endtask

  function automatic int exp_drop();
`ifdef MAC_DRAIN_DROP_CNT_EN
    return (drops > 255) ? 255 : drops;
`else
    return 0;
`endif
  endfunction

  task automatic push_row(input logic [63:0] a);
    exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.d = a[i*16 +: 16];
      e.i = 2'(i);
      e.l = (i == 3);
      q.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and hold monitor, sampled mid-cycle on the falling edge.
  logic        p_hold = 1'b0;
  logic [15:0] p_data;
  logic [1:0]  p_idx;
  logic        p_last;
  always @(negedge clk) begin
    if (!reset) begin
      if (p_hold) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'(out_data), int'(p_data));
        chk("hold_idx", int'(out_idx), int'(p_idx));
        chk("hold_last", int'(out_last), int'(p_last));
      end
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_word", int'(out_data), -1);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("word_data", int'(out_data), int'(e.d));
          chk("word_idx", int'(out_idx), int'(e.i));
          chk("word_last", int'(out_last), int'(e.l));
        end
      end
      p_hold = out_valid && !out_ready;
      p_data = out_data;
      p_idx  = out_idx;
      p_last = out_last;
    end else begin
      p_hold = 1'b0;
    end
  end

  vec_t vecs[5];

  initial begin
    int n;
    int clr_bad;
    vecs[0] = '{acc: {16'd24, 16'd18, 16'd12, 16'd6},             rdy: 8'hFF, cap: 2'd0, cyc: 8'd4};
    vecs[1] = '{acc: {16'd24, 16'd18, 16'd12, 16'd6},             rdy: 8'hD2, cap: 2'd1, cyc: 8'd8};
    vecs[2] = '{acc: {16'hDEF0, 16'h9ABC, 16'h5678, 16'h1234},    rdy: 8'h55, cap: 2'd0, cyc: 8'd7};
    vecs[3] = '{acc: {16'h0000, 16'h0001, 16'h8000, 16'hFFFF},    rdy: 8'hFF, cap: 2'd2, cyc: 8'd4};
    vecs[4] = '{acc: {16'hA5A5, 16'h5A5A, 16'h00FF, 16'hFF00},    rdy: 8'hF0, cap: 2'd2, cyc: 8'd8};

    // Reset for two cycles with a capture strobe that must be ignored.
    reset = 1'b1; capture = 1'b1; out_ready = 1'b1; acc_in = {$urandom, $urandom};
    step(); step();
    reset = 1'b0; capture = 1'b0;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_ready", int'(capture_ready), 1);
    chk("rst_data", int'(out_data), 0);
    chk("rst_idx", int'(out_idx), 0);
    chk("rst_last", int'(out_last), 0);
    chk("rst_clear", int'(mac_clear), 0);
    chk("rst_drop", int'(drop_cnt), 0);
    step();
    chk("idle_after_rst", int'(out_valid), 0);

    // Table rows, each captured in the first idle cycle after the previous row.
    for (int v = 0; v < 5; v++) begin
      chk("cap_ready_pre", int'(capture_ready), 1);
      acc_in = vecs[v].acc; capture = 1'b1; out_ready = 1'b1;
      push_row(vecs[v].acc);
      step();
      chk("first_valid", int'(out_valid), 1);
      chk("first_idx", int'(out_idx), 0);
      chk("clear_pulse", int'(mac_clear), 1);
      n = 0; clr_bad = 0;
      while (!capture_ready && n < 40) begin
        out_ready = vecs[v].rdy[n % 8];
        capture = (vecs[v].cap == 2'd2) || (vecs[v].cap == 2'd1 && n == 0);
        acc_in = capture ? {4{16'd1}} : {$urandom, $urandom};
        step();
        n++;
        if (mac_clear) clr_bad++;
      end
      capture = 1'b0;
      if (vecs[v].cap == 2'd1) drops += 1;
      else if (vecs[v].cap == 2'd2) drops += int'(vecs[v].cyc);
      chk("drain_cycles", n, int'(vecs[v].cyc));
      chk("clear_once", clr_bad, 0);
      chk("sb_empty", q.size(), 0);
      chk("drop_cnt", int'(drop_cnt), exp_drop());
    end

    // Hold one row under backpressure while 300 captures are dropped.
    acc_in = {16'h0404, 16'h0303, 16'h0202, 16'h0101}; capture = 1'b1; out_ready = 1'b0;
    push_row(acc_in);
    step();
    for (int i = 0; i < 300; i++) begin
      capture = 1'b1; acc_in = {$urandom, $urandom};
      step();
    end
    capture = 1'b0;
    drops += 300;
    chk("sat_valid", int'(out_valid), 1);
    chk("sat_data", int'(out_data), 16'h0101);
    chk("sat_drop", int'(drop_cnt), exp_drop());
    out_ready = 1'b1;
    n = 0;
    while (!capture_ready && n < 20) begin step(); n++; end
    chk("sat_drain", n, 4);
    chk("sat_sb_empty", q.size(), 0);

    // Reset after word 1 has transferred.
    acc_in = {16'h0044, 16'h0033, 16'h0022, 16'h0011}; capture = 1'b1; out_ready = 1'b1;
    push_row(acc_in);
    step();
    capture = 1'b0;
    step(); step();
    chk("mid_idx", int'(out_idx), 2);
    reset = 1'b1; out_ready = 1'b0;
    step();
    chk("mid_rst_valid", int'(out_valid), 0);
    chk("mid_rst_clear", int'(mac_clear), 0);
    reset = 1'b0;
    q.delete();
    drops = 0;
    step();
    chk("post_valid", int'(out_valid), 0);
    chk("post_data", int'(out_data), 0);
    chk("post_idx", int'(out_idx), 0);
    chk("post_last", int'(out_last), 0);
    chk("post_drop", int'(drop_cnt), 0);
    chk("post_ready", int'(capture_ready), 1);
    clr_bad = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (mac_clear) clr_bad++;
    end
    chk("post_no_clear", clr_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mac_result_drain.md
MAC_RESULT_DRAIN -- requirements
Module: mac_result_drain

Interface
REQ-001 The block SHALL have parameter N_MAC, default 4, the number of MAC accumulators captured per result row.
REQ-002 The block SHALL have parameter ACC_W, default 16, the accumulator width in bits.
REQ-003 The block SHALL have parameter IDX_W, default 2, the width of the element index; it SHALL satisfy 2**IDX_W >= N_MAC.
REQ-004 Port `clk`, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port `reset`, input, 1 bit: synchronous, active-high reset.
REQ-006 Port `capture`, input, 1 bit: single-cycle strobe meaning the MAC row results are final.
REQ-007 Port `acc_in`, input, N_MAC*ACC_W bits: packed accumulator outputs; element i occupies bits [i*ACC_W +: ACC_W].
REQ-008 Port `capture_ready`, output, 1 bit: high when a `capture` will be accepted.
REQ-009 Port `mac_clear`, output, 1 bit: one-cycle pulse that clears the MAC accumulators (drives the MAC `reset`).
REQ-010 Port `out_valid`, output, 1 bit: a result word is presented.
REQ-011 Port `out_ready`, input, 1 bit: the downstream accepts the word.
REQ-012 Port `out_data`, output, ACC_W bits: the result word.
REQ-013 Port `out_idx`, output, IDX_W bits: the element index of `out_data`.
REQ-014 Port `out_last`, output, 1 bit: marks the final word of a row.
REQ-015 Port `drop_cnt`, output, 8 bits: count of dropped capture strobes.

Function
REQ-016 The FSM SHALL have exactly two states, IDLE and SEND.
REQ-017 In IDLE, `capture_ready` SHALL be 1 and `out_valid` SHALL be 0.
REQ-018 In IDLE, `capture`=1 SHALL latch all N_MAC elements of `acc_in` into an internal buffer on that edge, set idx=0, and go to SEND.
REQ-019 `mac_clear` SHALL be 1 for exactly the one cycle following an accepted capture, and 0 otherwise.
REQ-020 In SEND, `out_valid` SHALL be 1, `out_data` SHALL equal buf[idx], `out_idx` SHALL equal idx, and `out_last` SHALL equal (idx==N_MAC-1).
REQ-021 The first word SHALL be valid in the cycle immediately after the accepted capture (latency 1).
REQ-022 A word SHALL transfer only on an edge where `out_valid`=1 and `out_ready`=1.
REQ-023 On a non-last transfer, idx SHALL increment by 1.
REQ-024 On the last transfer, the FSM SHALL return to IDLE.
REQ-025 `out_data`, `out_idx` and `out_last` SHALL be held stable while `out_valid`=1 and `out_ready`=0.
REQ-026 With `out_ready` held at 1, one word SHALL transfer per cycle, so a row drains in N_MAC cycles.
REQ-027 A `capture` in SEND, including in the cycle of the last transfer, SHALL be ignored and SHALL NOT alter the buffer.
REQ-028 `capture` SHALL be accepted again in the first IDLE cycle after a row completes.
REQ-029 `out_ready` SHALL have no effect in IDLE.
REQ-030 `acc_in` SHALL be sampled only on the capture edge; later changes SHALL NOT affect the output words.
REQ-031 Buffer words SHALL be stored unmodified at full ACC_W width, with no arithmetic.

Reset
REQ-032 While `reset`=1 at an edge: state=IDLE, idx=0, `out_valid`=0, `out_last`=0, `out_idx`=0, `out_data`=0, `mac_clear`=0, `drop_cnt`=0, and the buffer is cleared to 0.
REQ-033 A reset asserted mid-row SHALL abandon the row, with `out_valid`=0 in the following cycle.
REQ-034 A reset asserted mid-row SHALL produce no `mac_clear` pulse.
REQ-035 `capture` SHALL be ignored in any cycle where `reset`=1.

Configuration
REQ-036 With macro MAC_DRAIN_DROP_CNT_EN defined, `drop_cnt` SHALL increment on every edge where `capture`=1 in SEND.
REQ-037 With MAC_DRAIN_DROP_CNT_EN defined, `drop_cnt` SHALL saturate at 255.
REQ-038 With MAC_DRAIN_DROP_CNT_EN undefined, `drop_cnt` SHALL be constant 0, no counter logic SHALL be synthesized, and all other behaviour SHALL be identical.

Verification
REQ-039 Scenario, basic row drain:
- Stimulus: `reset` for 2 cycles; `acc_in` elements = {6,12,18,24} for elements 0..3; `capture` pulsed; `out_ready`=1.
- Required response: `mac_clear` pulses for 1 cycle.
- Required response: words 6,12,18,24 appear on 4 consecutive cycles with `out_idx` 0..3.
- Required response: `out_last` is 1 only with value 24.
- Required response: `capture_ready` returns to 1 on the next cycle.
REQ-040 Scenario, backpressure:
- Stimulus: as REQ-039, with `out_ready` toggling 0,1,0,0,1,…
- Required response: each word is held stable while `out_ready`=0.
- Required response: exactly 4 transfers occur, in order, with no duplicates.
REQ-041 Scenario, capture while busy:
- Stimulus: a second `capture` in SEND with `acc_in` elements = {1,1,1,1}.
- Required response: the original words are still emitted.
- Required response: `drop_cnt`=1 with the macro defined, and 0 without.
REQ-042 Scenario, back-to-back rows:
- Stimulus: a `capture` in the first IDLE cycle after the last transfer, then 300 dropped captures.
- Required response: the second row is accepted.
- Required response: `drop_cnt` saturates at 255 with the macro defined.
REQ-043 Scenario, reset mid-row:
- Stimulus: `reset` asserted after word 1 has transferred.
- Required response: `out_valid`=0 on the next cycle.
- Required response: all outputs are 0 and `capture_ready`=1 after `reset` deasserts.
- Required response: no `mac_clear` pulse occurs.
